// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame sequencer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  // TX_OUT source select; idle and load share the stop-level source.
  localparam logic [1:0] SEL_START = 2'd0;
  localparam logic [1:0] SEL_DATA  = 2'd1;
  localparam logic [1:0] SEL_PAR   = 2'd2;
  localparam logic [1:0] SEL_STOP  = 2'd3;

  localparam logic IDLE_LEVEL = 1'b1;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_parity_calc.sv
// Combinational parity of a data word; odd parity inverts the XOR reduction.
module uart_parity_calc
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  par_typ,
  output logic                  par_bit
);

  assign par_bit = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_frame_sel.sv
// UART transmit frame sequencer: captures a word, then drives start, data,
// optional parity and stop bits on a registered line, one bit per TICK.
module uart_tx_frame_sel
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter bit LSB_FIRST  = 1'b1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  TICK,
  input  logic                  DATA_VALID,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY,
  output logic                  DONE
);

  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  tx_state_t             state, state_nxt;
  logic [CW-1:0]         cnt, cnt_nxt, bit_idx;
  logic [DATA_WIDTH-1:0] data_r;
  logic                  par_en_r, par_r, par_calc;
  logic                  accept, frame_end, tx_nxt;
  logic [1:0]            sel;

  assign accept    = DATA_VALID && !BUSY;
  assign frame_end = (state == STOP) && (state_nxt == IDLE);

  uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
    .data    (P_DATA),
    .par_typ (PAR_TYP),
    .par_bit (par_calc)
  );

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE:   if (accept) state_nxt = LOAD;
      LOAD:   if (TICK) state_nxt = START;
      START:  if (TICK) begin
                state_nxt = DATA;
                cnt_nxt   = '0;
              end
      DATA:   if (TICK) begin
                if (cnt == DATA_LAST) begin
                  state_nxt = par_en_r ? PARITY : STOP;
                  cnt_nxt   = '0;
                end else begin
                  cnt_nxt = cnt + CW'(1);
                end
              end
      PARITY: if (TICK) begin
                state_nxt = STOP;
                cnt_nxt   = '0;
              end
      STOP:   if (TICK) begin
                if (cnt == STOP_LAST) state_nxt = IDLE;
                else                  cnt_nxt   = cnt + CW'(1);
              end
      default: state_nxt = IDLE;
    endcase
  end

  // The line register is loaded from the state being entered, so every bit
  // appears on the same edge as its state change.
  always_comb begin
    sel = SEL_STOP;
    case (state_nxt)
      START:   sel = SEL_START;
      DATA:    sel = SEL_DATA;
      PARITY:  sel = SEL_PAR;
      default: sel = SEL_STOP;
    endcase
    bit_idx = LSB_FIRST ? cnt_nxt : DATA_LAST - cnt_nxt;
    case (sel)
      SEL_START: tx_nxt = ~IDLE_LEVEL;
      SEL_DATA:  tx_nxt = data_r[bit_idx];
      SEL_PAR:   tx_nxt = par_r;
      default:   tx_nxt = IDLE_LEVEL;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= IDLE;
      cnt      <= '0;
      data_r   <= '0;
      par_en_r <= 1'b0;
      par_r    <= 1'b0;
      TX_OUT   <= IDLE_LEVEL;
      BUSY     <= 1'b0;
      DONE     <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      TX_OUT <= tx_nxt;
      DONE   <= frame_end;
      if (accept) begin
        data_r   <= P_DATA;
        par_en_r <= PAR_EN;
        par_r    <= par_calc;
        BUSY     <= 1'b1;
      end else if (frame_end) begin
        BUSY <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_tx_frame_sel.md
# uart_tx_frame_sel

Parametrised, registered UART transmit frame sequencer and output selector. It captures a parallel word, then drives the serial line through start, data, optional parity and stop bits, one bit per bit-rate tick. It sits between the TX data source and the TX pin and replaces the fixed 4-input line selector. It adds a configurable data width, stop-bit count, bit order and parity mode, plus a valid/busy handshake and a glitch-free registered line output.

## Interface
Parameters:
- DATA_WIDTH, 8: data bits per frame, legal range 5..9.
- STOP_BITS, 1: stop bits per frame, 1 or 2.
- LSB_FIRST, 1: 1 sends bit 0 first; 0 sends bit DATA_WIDTH-1 first.

Ports:
- CLK  in  1  system clock.
- RST  in  1  asynchronous, active-low reset.
- TICK  in  1  bit-rate enable, one CLK cycle wide; bit boundaries occur only on edges with TICK=1.
- DATA_VALID  in  1  request to send P_DATA.
- P_DATA  in  DATA_WIDTH  word to transmit.
- PAR_EN  in  1  1 inserts a parity bit.
- PAR_TYP  in  1  0 selects even parity, 1 selects odd parity.
- TX_OUT  out  1  serial line, registered, idle high.
- BUSY  out  1  high from accept until the frame ends.
- DONE  out  1  one-CLK pulse at frame end.

## Operation
- States: IDLE, LOAD, START, DATA, PARITY, STOP.
- Accept: on a CLK edge with DATA_VALID=1 and BUSY=0:
  - P_DATA, PAR_EN and PAR_TYP are captured.
  - The parity bit is computed: XOR of data for even, inverted XOR for odd.
  - BUSY goes to 1 and the state goes to LOAD.
  - Later input changes do not affect the frame in flight.
- DATA_VALID with BUSY=1 is ignored. It is not queued.
- State transitions happen only on edges with TICK=1:
  - LOAD→START
  - START→DATA
  - DATA→DATA until DATA_WIDTH bits have been sent, then →PARITY if PAR_EN was captured as 1, else →STOP
  - PARITY→STOP
  - STOP→STOP until STOP_BITS bits have been sent, then →IDLE
- TX_OUT is registered and follows the state entered: IDLE/LOAD=1, START=0, DATA=current data bit, PARITY=parity bit, STOP=1.
- Bit counter: width is clog2(DATA_WIDTH). It is cleared on entry to DATA and on entry to STOP, and increments on each TICK within those states.
- On STOP→IDLE: BUSY goes to 0 and DONE=1 for exactly one CLK.
- Reset (RST=0, any state, including mid-frame): state=IDLE, TX_OUT=1, BUSY=0, DONE=0, counter=0, captured data=0. This is immediate and asynchronous.

## Timing
- Accept edge to start bit: the start bit appears on the first TICK edge strictly after the accept edge. TICK on the accept edge itself does not advance the state.
- Each bit lasts exactly one TICK period.
- Frame length in TICK periods: 1 + DATA_WIDTH + PAR_EN + STOP_BITS.
- DONE and the BUSY fall happen on the same edge that returns TX_OUT to idle after the last stop bit.
- Back-to-back frames:
  - DATA_VALID held high across the frame end is accepted on the first edge with BUSY=0, i.e. one CLK after DONE.
  - The next start bit follows on the next TICK edge.
- TICK held at 1 continuously is legal: one bit per CLK.

## Structure
- Shared package uart_tx_pkg:
  - state enum type
  - TX_OUT select codes SEL_START/SEL_DATA/SEL_PAR/SEL_STOP
  - IDLE_LEVEL=1
  - parity-type constants PAR_EVEN=0 and PAR_ODD=1
- Sub-module uart_parity_calc: parametrised on DATA_WIDTH, combinational XOR reduction with the PAR_TYP invert. It is instantiated once at capture.
- The FSM, counter, shift/index logic and output register stay in the top module.

## Test plan
- Reset value:
  - Stimulus: RST=0 asserted mid-data-bit of a frame.
  - Required: TX_OUT=1, BUSY=0 and DONE=0 immediately, without a CLK edge.
  - After release with no DATA_VALID: the line stays 1.
- 8N1, LSB first:
  - Stimulus: TICK=1 constant, P_DATA=0xA5, PAR_EN=0.
  - Required TX_OUT per CLK after LOAD: 0,1,0,1,0,0,1,0,1,1.
  - Required flags: DONE pulses once, and BUSY spans 11 edges.
- Parity:
  - Stimulus: 0xA5 with PAR_EN=1.
  - Required: PAR_TYP=0 gives parity bit 0; PAR_TYP=1 gives parity bit 1.
  - Stimulus: 0x07 with PAR_TYP=0.
  - Required: parity bit 1.
- Parameters:
  - Stimulus: DATA_WIDTH=7, STOP_BITS=2, LSB_FIRST=0, P_DATA=0x41.
  - Required: start bit, then 1,0,0,0,0,0,1, then two stop bits of 1.
  - Required: DONE only after the second stop bit.
- Sparse TICK and handshake:
  - Stimulus: TICK every 16 CLK. Change P_DATA and pulse DATA_VALID while BUSY=1.
  - Required: each bit held exactly 16 CLK.
  - Required: the in-flight frame is unchanged and the second request is not sent.
- Back-to-back:
  - Stimulus: DATA_VALID held high with 0x55 then 0xAA.
  - Required: the second accept occurs one CLK after DONE.
  - Required: the second start bit follows on the next TICK edge.
  - Required: no glitch on TX_OUT between the frames.
